// File: rtl/rstp_seq_ctrl_if.sv
// Control/observe bundle between frame-level logic and the RStpCnt sequencer.
// master drives commands and the counter feedback; slave is the sequencer.
interface rstp_seq_ctrl_if #(
  parameter int BIT_W = 5,
  parameter int LEN_W = 4
);
  logic             start_i;
  logic             abort_i;
  logic [LEN_W-1:0] som_len_i;
  logic [BIT_W-1:0] stop_lim_i;
  logic [LEN_W-1:0] hold_len_i;
  logic [LEN_W-1:0] rel_len_i;
  logic [BIT_W-1:0] cnt_i;
  logic             som_o;
  logic             stop_o;
  logic             blkf_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [2:0]       state_o;

  modport master (
    output start_i, abort_i, som_len_i, stop_lim_i, hold_len_i, rel_len_i, cnt_i,
    input  som_o, stop_o, blkf_o, busy_o, done_o, err_o, state_o
  );

  modport slave (
    input  start_i, abort_i, som_len_i, stop_lim_i, hold_len_i, rel_len_i, cnt_i,
    output som_o, stop_o, blkf_o, busy_o, done_o, err_o, state_o
  );
endinterface

// File: rtl/rstp_seq_ctrl.sv
// Frame sequencer for the RStpCnt register-counter stop block: SOM, STOP,
// BLOCK, RELEASE, with STOP timeout and abort.
//
//   state   | meaning
//   IDLE    | waiting for start; done_o pulses here after a normal frame
//   SOM     | som strobe only, fixed length
//   STOP    | som+stop until cnt_i >= stop limit or timeout
//   BLOCK   | stop+blkf, fixed length
//   RELEASE | blkf only, fixed length
module rstp_seq_ctrl #(
  parameter int BIT_W = 5,
  parameter int LEN_W = 4,
  parameter int TMO   = 64
) (
  input logic           clk_i,
  input logic           rst_ni,
  rstp_seq_ctrl_if.slave bus
);

  localparam int TW = (TMO > 2) ? $clog2(TMO) : 1;
  localparam int PW = (LEN_W > TW) ? LEN_W : TW;
  localparam logic [PW-1:0] TMO_LD = PW'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SOM   = 3'd1,
    S_STOP  = 3'd2,
    S_BLOCK = 3'd3,
    S_REL   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ph_q, ph_d;
  logic [BIT_W-1:0] lim_q, lim_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [LEN_W-1:0] rel_q, rel_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic             som_q, stop_q, blkf_q, busy_q;

  // Phase counter counts down to 0; a length of 0 behaves as 1.
  function automatic logic [PW-1:0] len_ld(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : PW'(len - LEN_W'(1));
  endfunction

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    lim_d   = lim_q;
    hold_d  = hold_q;
    rel_d   = rel_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start_i) begin
        state_d = S_SOM;
        ph_d    = len_ld(bus.som_len_i);
        lim_d   = bus.stop_lim_i;
        hold_d  = bus.hold_len_i;
        rel_d   = bus.rel_len_i;
        err_d   = 1'b0;
      end
      S_SOM: if (ph_q == '0) begin
        state_d = S_STOP;
        ph_d    = TMO_LD;
      end else ph_d = ph_q - PW'(1);
      // Compare is checked first so it wins over a coincident timeout.
      S_STOP: if (bus.cnt_i >= lim_q) begin
        state_d = S_BLOCK;
        ph_d    = len_ld(hold_q);
      end else if (ph_q == '0) begin
        state_d = S_BLOCK;
        ph_d    = len_ld(hold_q);
        err_d   = 1'b1;
      end else ph_d = ph_q - PW'(1);
      S_BLOCK: if (ph_q == '0) begin
        state_d = S_REL;
        ph_d    = len_ld(rel_q);
      end else ph_d = ph_q - PW'(1);
      S_REL: if (ph_q == '0) begin
        state_d = S_IDLE;
        ph_d    = '0;
        done_d  = 1'b1;
      end else ph_d = ph_q - PW'(1);
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && bus.abort_i) begin
      state_d = S_IDLE;
      ph_d    = '0;
      err_d   = err_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      lim_q   <= '0;
      hold_q  <= '0;
      rel_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      som_q   <= 1'b0;
      stop_q  <= 1'b0;
      blkf_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      lim_q   <= lim_d;
      hold_q  <= hold_d;
      rel_q   <= rel_d;
      err_q   <= err_d;
      done_q  <= done_d;
      som_q   <= (state_d == S_SOM) || (state_d == S_STOP);
      stop_q  <= (state_d == S_STOP) || (state_d == S_BLOCK);
      blkf_q  <= (state_d == S_BLOCK) || (state_d == S_REL);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign bus.som_o   = som_q;
  assign bus.stop_o  = stop_q;
  assign bus.blkf_o  = blkf_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.err_o   = err_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_rstp_seq_ctrl.sv
// Directed vector bench for rstp_seq_ctrl: one row per clock edge with
// hand-derived expected state/err/done, plus a bounded done-wait sequence.
module tb_rstp_seq_ctrl;

  localparam logic [2:0] I = 3'd0, SM = 3'd1, ST = 3'd2, BK = 3'd3, RL = 3'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rstp_seq_ctrl_if #(.BIT_W(5), .LEN_W(4)) bus ();

  rstp_seq_ctrl #(.BIT_W(5), .LEN_W(4), .TMO(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic       rst_n, start, abort;
    logic [4:0] cnt, lim;
    logic [3:0] som, hold, rel;
    logic [2:0] st;
    logic       err, done;
  } row_t;

  row_t rows[$];
  logic [3:0] c_som, c_hold, c_rel;
  logic [4:0] c_lim;
  int checks = 0;
  int errors = 0;

  function automatic logic [8:0] expv(input logic [2:0] st, input logic err, input logic done);
    logic [3:0] o;
    case (st)
      3'd1:    o = 4'b1001;
      3'd2:    o = 4'b1101;
      3'd3:    o = 4'b0111;
      3'd4:    o = 4'b0011;
      default: o = 4'b0000;
    endcase
    return {o, done, err, st};
  endfunction

  task automatic add(input logic r, input logic s, input logic a, input logic [4:0] cnt,
                     input logic [2:0] st, input logic err, input logic done);
    row_t x;
    x.rst_n = r; x.start = s; x.abort = a; x.cnt = cnt;
    x.lim = c_lim; x.som = c_som; x.hold = c_hold; x.rel = c_rel;
    x.st = st; x.err = err; x.done = done;
    rows.push_back(x);
  endtask

  task automatic add_n(input int n, input logic s, input logic [4:0] cnt,
                       input logic [2:0] st, input logic err);
    for (int k = 0; k < n; k++) add(1, s, 0, cnt, st, err, 0);
  endtask

  task automatic cfg(input logic [3:0] s, input logic [4:0] l, input logic [3:0] h, input logic [3:0] r);
    c_som = s; c_lim = l; c_hold = h; c_rel = r;
  endtask

  function automatic logic [8:0] got();
    return {bus.som_o, bus.stop_o, bus.blkf_o, bus.busy_o, bus.done_o, bus.err_o, bus.state_o};
  endfunction

  initial begin
    bus.start_i = 0; bus.abort_i = 0; bus.cnt_i = 0;
    bus.som_len_i = 0; bus.stop_lim_i = 0; bus.hold_len_i = 0; bus.rel_len_i = 0;

    // Reset, then normal frame 4/5/4/5 with cnt_i ramping during STOP.
    cfg(4, 5, 4, 5);
    add(0, 0, 0, 0, I, 0, 0);
    add(0, 1, 1, 0, I, 0, 0);
    add(1, 0, 0, 0, I, 0, 0);
    add(1, 1, 0, 0, SM, 0, 0);
    add_n(3, 0, 0, SM, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 5'(k), ST, 0, 0);
    add(1, 0, 0, 5, BK, 0, 0);
    add_n(3, 0, 0, BK, 0);
    add(1, 0, 0, 0, RL, 0, 0);
    add_n(4, 0, 0, RL, 0);
    add(1, 0, 0, 0, I, 0, 1);
    add(1, 0, 0, 0, I, 0, 0);

    // Timeout: STOP held exactly 64 cycles, err sticky, abort in IDLE ignored.
    cfg(1, 31, 1, 1);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    add_n(63, 0, 0, ST, 0);
    add(1, 0, 0, 0, BK, 1, 0);
    add(1, 0, 0, 0, RL, 1, 0);
    add(1, 0, 0, 0, I, 1, 1);
    add(1, 0, 0, 0, I, 1, 0);
    add(1, 0, 1, 0, I, 1, 0);

    // Compare and timeout on the same edge; config changed mid-frame.
    cfg(0, 3, 0, 0);
    add(1, 1, 0, 0, SM, 0, 0);
    cfg(15, 0, 15, 15);
    add(1, 0, 0, 0, ST, 0, 0);
    add_n(63, 0, 0, ST, 0);
    add(1, 0, 0, 3, BK, 0, 0);
    add(1, 0, 0, 0, RL, 0, 0);
    add(1, 0, 0, 0, I, 0, 1);

    // All-zero lengths and limit: four 1-cycle phases.
    cfg(0, 0, 0, 0);
    add(1, 0, 0, 0, I, 0, 0);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    add(1, 0, 0, 0, BK, 0, 0);
    add(1, 0, 0, 0, RL, 0, 0);
    add(1, 0, 0, 0, I, 0, 1);

    // Abort on the BLOCK exit edge; start held is ignored mid-frame.
    cfg(1, 0, 2, 1);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 1, 0, 0, ST, 0, 0);
    add(1, 1, 0, 0, BK, 0, 0);
    add(1, 1, 0, 0, BK, 0, 0);
    add(1, 1, 1, 0, I, 0, 0);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    add(1, 0, 0, 0, BK, 0, 0);
    add(1, 0, 0, 0, BK, 0, 0);
    add(1, 0, 0, 0, RL, 0, 0);
    add(1, 0, 0, 0, I, 0, 1);

    // Back-to-back frames with start held high.
    cfg(0, 0, 0, 0);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 1, 0, 0, ST, 0, 0);
    add(1, 1, 0, 0, BK, 0, 0);
    add(1, 1, 0, 0, RL, 0, 0);
    add(1, 1, 0, 0, I, 0, 1);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    add(1, 0, 0, 0, BK, 0, 0);
    add(1, 0, 0, 0, RL, 0, 0);
    add(1, 0, 0, 0, I, 0, 1);

    // Reset mid-STOP with start high; start accepted once reset releases.
    cfg(1, 31, 1, 1);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    add(1, 0, 0, 0, ST, 0, 0);
    add(0, 1, 0, 0, I, 0, 0);
    add(0, 1, 0, 0, I, 0, 0);
    add(1, 1, 0, 0, SM, 0, 0);
    add(1, 0, 1, 0, I, 0, 0);

    for (int i = 0; i < rows.size(); i++) begin
      rst_n          = rows[i].rst_n;
      bus.start_i    = rows[i].start;
      bus.abort_i    = rows[i].abort;
      bus.cnt_i      = rows[i].cnt;
      bus.stop_lim_i = rows[i].lim;
      bus.som_len_i  = rows[i].som;
      bus.hold_len_i = rows[i].hold;
      bus.rel_len_i  = rows[i].rel;
      @(posedge clk); #1;
      checks++;
      if (got() !== expv(rows[i].st, rows[i].err, rows[i].done)) begin
        errors++;
        $display("FAIL row%0d som/stop/blkf/busy/done/err/state got=%b exp=%b",
                 i, got(), expv(rows[i].st, rows[i].err, rows[i].done));
      end
    end

    // Frame 2/2/2/2 with cnt_i already at the limit: busy for 2+1+2+2 cycles, one done.
    begin
      int busy_n = 0, done_n = 0, cyc = 0;
      bus.start_i = 0; bus.abort_i = 0;
      bus.som_len_i = 2; bus.stop_lim_i = 2; bus.hold_len_i = 2; bus.rel_len_i = 2;
      bus.cnt_i = 2;
      @(posedge clk); #1;
      bus.start_i = 1;
      @(posedge clk); #1;
      bus.start_i = 0;
      while (bus.done_o !== 1'b1 && cyc < 50) begin
        if (bus.busy_o === 1'b1) busy_n++;
        @(posedge clk); #1;
        cyc++;
      end
      checks++;
      if (cyc >= 50) begin
        errors++;
        $display("FAIL done_wait got=timeout exp=done within 50 cycles");
      end
      done_n = (bus.done_o === 1'b1) ? 1 : 0;
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) done_n++;
      checks++;
      if (busy_n != 7) begin
        errors++;
        $display("FAIL busy_len got=%0d exp=7", busy_n);
      end
      checks++;
      if (done_n != 1) begin
        errors++;
        $display("FAIL done_pulses got=%0d exp=1", done_n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
